// File: rtl/cflog_reader.sv
// Log drain sequencer: walks a list of (src, dest) word pairs in the log RAM.
// For each entry it presents src, dest and the loop tag on a valid/ready bus.
// It pulses done when the list is exhausted.
module cflog_reader #(
    parameter int ADDR_W = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [ADDR_W-2:0] i_num_entries,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [15:0]       i_mem_rdata,
    input  logic              i_tag_rdata,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [15:0]       o_out_src,
    output logic [15:0]       o_out_dest,
    output logic              o_out_loop,
    output logic [31:0]       o_out_loop_ctr,
    output logic              o_busy,
    output logic              o_done
);

    // state     | meaning
    // S_IDLE    | waiting for start
    // S_RD_SRC  | src word read strobed at ptr
    // S_RD_DST  | dest word read strobed at ptr+1, src and tag captured
    // S_CAP_DST | dest word captured, output bus loaded
    // S_PRESENT | entry offered on out_*, waiting for out_ready
    // S_DONE    | one-cycle completion pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_SRC,
        S_RD_DST,
        S_CAP_DST,
        S_PRESENT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-2:0] CNT_ONE = {{(ADDR_W-2){1'b0}}, 1'b1};

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-2:0] r_cnt;
    logic [15:0]       r_src;
    logic              r_loop;

    // Pointer arithmetic wraps naturally at the ADDR_W boundary.
    logic [ADDR_W-1:0] w_ptr_plus1;
    logic [ADDR_W-1:0] w_ptr_plus2;
    assign w_ptr_plus1 = r_ptr + ADDR_W'(1);
    assign w_ptr_plus2 = r_ptr + ADDR_W'(2);

    // Sequencer with all outputs registered alongside the state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_src          <= '0;
            r_loop         <= 1'b0;
            o_mem_rd       <= 1'b0;
            o_mem_addr     <= '0;
            o_out_valid    <= 1'b0;
            o_out_src      <= '0;
            o_out_dest     <= '0;
            o_out_loop     <= 1'b0;
            o_out_loop_ctr <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (i_abort && (r_state != S_IDLE)) begin
                // Abort wins over any handshake and suppresses done.
                r_state        <= S_IDLE;
                o_mem_rd       <= 1'b0;
                o_mem_addr     <= '0;
                o_out_valid    <= 1'b0;
                o_out_src      <= '0;
                o_out_dest     <= '0;
                o_out_loop     <= 1'b0;
                o_out_loop_ctr <= '0;
                o_busy         <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            o_busy <= 1'b1;
                            if (i_num_entries != '0) begin
                                r_ptr      <= i_base_addr;
                                r_cnt      <= i_num_entries;
                                o_mem_rd   <= 1'b1;
                                o_mem_addr <= i_base_addr;
                                r_state    <= S_RD_SRC;
                            end else begin
                                o_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    end
                    S_RD_SRC: begin
                        o_mem_addr <= w_ptr_plus1;
                        r_state    <= S_RD_DST;
                    end
                    S_RD_DST: begin
                        r_src      <= i_mem_rdata;
                        r_loop     <= i_tag_rdata;
                        o_mem_rd   <= 1'b0;
                        o_mem_addr <= '0;
                        r_state    <= S_CAP_DST;
                    end
                    S_CAP_DST: begin
                        o_out_src      <= r_src;
                        o_out_dest     <= i_mem_rdata;
                        o_out_loop     <= r_loop;
                        o_out_loop_ctr <= r_loop ? {r_src, i_mem_rdata} : 32'd0;
                        o_out_valid    <= 1'b1;
                        r_state        <= S_PRESENT;
                    end
                    S_PRESENT: begin
                        if (i_out_ready) begin
                            o_out_valid <= 1'b0;
                            r_cnt       <= r_cnt - CNT_ONE;
                            r_ptr       <= w_ptr_plus2;
                            if (r_cnt == CNT_ONE) begin
                                o_done  <= 1'b1;
                                r_state <= S_DONE;
                            end else begin
                                o_mem_rd   <= 1'b1;
                                o_mem_addr <= w_ptr_plus2;
                                r_state    <= S_RD_SRC;
                            end
                        end
                    end
                    S_DONE: begin
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        o_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cflog_reader.sv
// Bench for cflog_reader: RAM model, reference model of the entry list, and a
// scoreboard monitor that checks read addresses and presented entries.
module tb_cflog_reader;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-2:0] num_entries = '0;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata = '0;
    logic          tag_rdata = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [15:0]   out_src, out_dest;
    logic          out_loop;
    logic [31:0]   out_loop_ctr;
    logic          busy, done;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dest;
        logic        loop;
        logic [31:0] ctr;
    } entry_t;

    entry_t      exp_q[$];
    int          addr_q[$];
    logic [15:0] ram[DEPTH];
    bit          tags[DEPTH];

    int checks = 0, errors = 0, cyc = 0;
    int ready_mode = 0;
    int done_cnt = 0, done_cyc = -1, hs_cnt = 0, last_hs_cyc = -1;
    int first_valid_cyc = -1, rd_cnt = 0;
    logic [31:0] last_ctr = '0;

    cflog_reader #(.ADDR_W(AW)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_base_addr(base_addr), .i_num_entries(num_entries),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr),
        .i_mem_rdata(mem_rdata), .i_tag_rdata(tag_rdata),
        .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_src(out_src), .o_out_dest(out_dest), .o_out_loop(out_loop),
        .o_out_loop_ctr(out_loop_ctr), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata <= ram[mem_addr];
            tag_rdata <= tags[mem_addr];
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor
    logic   prev_stall = 1'b0;
    logic   prev_done = 1'b0;
    entry_t prev_ent;
    always @(negedge clk) begin
        entry_t cur, e;
        cur = '{src: out_src, dest: out_dest, loop: out_loop, ctr: out_loop_ctr};
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (mem_rd) begin
                rd_cnt++;
                if (addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read actual=%0h expected=none", mem_addr);
                end else check("rd_addr", 128'(mem_addr), 128'(addr_q.pop_front()));
            end
            if (out_valid) begin
                check("no_rd_in_present", 128'(mem_rd), 128'(0));
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (prev_stall) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_data", 128'(cur), 128'(prev_ent));
            end
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_hs_cyc = cyc;
                last_ctr = out_loop_ctr;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_entry actual=%0h expected=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    check("entry", 128'(cur), 128'(e));
                end
            end
            if (prev_done) check("done_width", 128'(done), 128'(0));
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid && !out_ready;
            prev_ent   = cur;
            prev_done  = done;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model: entry k sits at (base + 2k) mod 2^AW, dest at the next word.
    task automatic load_expect(input int b, input int n);
        for (int k = 0; k < n; k++) begin
            int     a, d;
            entry_t e;
            a = (b + 2 * k) % DEPTH;
            d = (a + 1) % DEPTH;
            e.src  = ram[a];
            e.dest = ram[d];
            e.loop = tags[a];
            e.ctr  = tags[a] ? (32'(ram[a]) * 32'd65536 + 32'(ram[d])) : 32'd0;
            exp_q.push_back(e);
            addr_q.push_back(a);
            addr_q.push_back(d);
        end
    endtask

    task automatic drain(input int b, input int n, input int mode, input int stall,
                         input bit dbl, output int t0);
        int guard;
        load_expect(b, n);
        ready_mode      = mode;
        first_valid_cyc = -1;
        done_cyc        = -1;
        base_addr       = AW'(b);
        num_entries     = (AW-1)'(n);
        start           = 1'b1;
        t0              = cyc;
        tick();
        start = 1'b0;
        if (dbl) begin
            tick();
            check("busy_during_drain", 128'(busy), 128'(1));
            base_addr   = AW'(b + 100);
            num_entries = (AW-1)'(5);
            start       = 1'b1;
            tick();
            start = 1'b0;
        end
        if (stall > 0) begin
            guard = 0;
            while (first_valid_cyc < 0 && guard < 100) begin tick(); guard++; end
            check("stall_valid_seen", 128'(first_valid_cyc >= 0), 128'(1));
            tick(stall);
            ready_mode = 0;
        end
        guard = 0;
        while (done_cyc < t0 && guard < 2000) begin tick(); guard++; end
        check("done_seen", 128'(done_cyc >= t0), 128'(1));
        tick(2);
        check("idle_after", 128'(busy), 128'(0));
        check("queues_empty", 128'(exp_q.size() + addr_q.size()), 128'(0));
    endtask

    initial begin
        int t0, d0, r0, guard;
        for (int i = 0; i < DEPTH; i++) begin
            ram[i]  = 16'($urandom);
            tags[i] = 1'($urandom_range(0, 1));
        end

        // Reset state
        tick(3);
        check("reset_outputs",
              128'({busy, done, mem_rd, mem_addr, out_valid, out_src, out_dest, out_loop, out_loop_ctr}),
              128'(0));
        rst_n = 1'b1;
        tick(2);

        // Two plain entries, ready high
        ram[16'h10] = 16'hE000; ram[16'h11] = 16'hE0F4;
        ram[16'h12] = 16'hE100; ram[16'h13] = 16'hE010;
        tags[16'h10] = 1'b0; tags[16'h12] = 1'b0;
        drain(16'h010, 2, 0, 0, 1'b0, t0);
        check("latency", 128'(first_valid_cyc - t0), 128'(4));
        check("throughput", 128'(last_hs_cyc - first_valid_cyc), 128'(4));
        check("done_after_hs", 128'(done_cyc - last_hs_cyc), 128'(1));

        // Loop-counter entry
        ram[16'h100] = 16'h0000; ram[16'h101] = 16'h0005; tags[16'h100] = 1'b1;
        drain(16'h100, 1, 0, 0, 1'b0, t0);
        check("loop_ctr", 128'(last_ctr), 128'(32'h0000_0005));

        // Back-pressure for 10 cycles
        drain(16'h040, 2, 2, 10, 1'b0, t0);

        // Address wrap, plus a start pulse while busy
        drain(16'h3FE, 2, 0, 0, 1'b1, t0);

        // Zero entries
        r0 = rd_cnt;
        done_cyc = -1;
        base_addr = AW'(16'h20);
        num_entries = '0;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        tick(3);
        check("zero_done_cycle", 128'(done_cyc - t0), 128'(1));
        check("zero_no_reads", 128'(rd_cnt - r0), 128'(0));

        // Abort in RD_DST
        d0 = done_cnt;
        load_expect(16'h080, 3);
        base_addr = AW'(16'h080);
        num_entries = (AW-1)'(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        @(negedge clk);
        check("abort_outputs",
              128'({busy, done, mem_rd, out_valid, out_src, out_dest, out_loop_ctr}), 128'(0));
        tick(8);
        check("abort_no_done", 128'(done_cnt - d0), 128'(0));
        check("abort_idle", 128'(busy), 128'(0));
        exp_q.delete();
        addr_q.delete();

        // Reset while presenting
        d0 = done_cnt;
        load_expect(16'h0C0, 1);
        ready_mode = 2;
        first_valid_cyc = -1;
        base_addr = AW'(16'h0C0);
        num_entries = (AW-1)'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
        guard = 0;
        while (first_valid_cyc < 0 && guard < 50) begin tick(); guard++; end
        check("present_reached", 128'(out_valid), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs",
              128'({busy, done, mem_rd, mem_addr, out_valid, out_src, out_dest, out_loop, out_loop_ctr}),
              128'(0));
        tick(2);
        rst_n = 1'b1;
        ready_mode = 0;
        tick(6);
        check("rst_stays_idle", 128'({busy, mem_rd, out_valid}), 128'(0));
        check("rst_no_done", 128'(done_cnt - d0), 128'(0));
        exp_q.delete();
        addr_q.delete();

        // Randomized drains
        for (int it = 0; it < 25; it++) begin
            int b, n, m;
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 6);
            m = $urandom_range(0, 1);
            for (int k = 0; k < 2 * n; k++) ram[(b + k) % DEPTH] = 16'($urandom);
            drain(b, n, m, 0, 1'b0, t0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
